// File: rtl/vmem_pkg.sv
// vmem_pkg: shared types and limits for the vmem
// multi-channel read controller.
package vmem_pkg;

  localparam int VMEM_MAX_NCH    = 8;
  localparam int VMEM_MAX_RD_LAT = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    RESP
  } vmem_rd_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vmem_rr_arb.sv
// vmem_rr_arb: combinational round-robin picker, search
// starts one past the last grant and wraps modulo NCH.
module vmem_rr_arb
  import vmem_pkg::*;
#(
  parameter  int NCH = 2,
  localparam int IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  input  logic           en,
  output logic [NCH-1:0] gnt,
  output logic [IW-1:0]  idx
);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= NCH; k++) begin
      if (en && !found && req[(int'(ptr) + k) % NCH]) begin
        found = 1'b1;
        gnt[(int'(ptr) + k) % NCH] = 1'b1;
        idx = IW'((int'(ptr) + k) % NCH);
      end
    end
  end

endmodule

// File: rtl/vmem_rd_arb.sv
// vmem_rd_arb: round-robin multi-channel read controller
// for the vmem test memory, one read in flight.
module vmem_rd_arb
  import vmem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8,
  parameter int NCH    = 2,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NCH-1:0]        req_valid,
  output logic [NCH-1:0]        req_ready,
  input  logic [NCH*ADDR_W-1:0] req_addr,
  output logic [NCH-1:0]        rsp_valid,
  input  logic [NCH-1:0]        rsp_ready,
  output logic [DATA_W-1:0]     rsp_data,
  output logic [ADDR_W-1:0]     mem_raddr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy
);

  localparam int IW = idx_w(NCH);
  localparam int CW = $clog2(RD_LAT + 1);

  if (NCH < 1 || NCH > VMEM_MAX_NCH ||
      RD_LAT < 1 || RD_LAT > VMEM_MAX_RD_LAT) begin : g_bad
    $error("vmem_rd_arb: NCH or RD_LAT out of range");
  end

  vmem_rd_state_e state;
  logic [CW-1:0]  cnt;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  gidx;
  logic [IW-1:0]  widx;
  logic [NCH-1:0] gnt;

  vmem_rr_arb #(
    .NCH(NCH)
  ) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .en (state == IDLE),
    .gnt(gnt),
    .idx(widx)
  );

  assign req_ready = gnt;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ptr       <= IW'(NCH - 1);
      gidx      <= '0;
      mem_raddr <= '0;
      rsp_data  <= '0;
      rsp_valid <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|gnt) begin
            gidx      <= widx;
            ptr       <= widx;
            mem_raddr <= req_addr[widx*ADDR_W +: ADDR_W];
            cnt       <= '0;
            state     <= READ;
          end
        end
        READ: begin
          if (cnt == CW'(RD_LAT - 1)) begin
            cnt       <= '0;
            rsp_data  <= mem_rdata;
            rsp_valid <= NCH'(1) << gidx;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          // only the granted channel's ready can close it
          if (|(rsp_valid & rsp_ready)) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
